// File: rtl/vram_brush_painter_pkg.sv
// Shared types and defaults for the VRAM brush painter.
// Holds the FSM state enum, display defaults and ILI9341 colours.
package vram_painter_pkg;

   localparam int DISPLAY_WIDTH_DEF  = 240;
   localparam int DISPLAY_HEIGHT_DEF = 320;

   typedef logic [15:0] ILI9341_color_t;

   localparam ILI9341_color_t BLACK = 16'h0000;
   localparam ILI9341_color_t WHITE = 16'hFFFF;
   localparam ILI9341_color_t RED   = 16'hF800;
   localparam ILI9341_color_t GREEN = 16'h07E0;
   localparam ILI9341_color_t BLUE  = 16'h001F;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_BRUSH
   } state_t;

endpackage

// File: rtl/vram_brush_painter_if.sv
// Touch/clear request bus plus VRAM write port of the brush painter.
// slave = painter side, master = touch source / VRAM sink side.
interface vram_brush_painter_if
   import vram_painter_pkg::*;
#(
   parameter int COLOR_W = $bits(ILI9341_color_t),
   parameter int R_W     = 2,
   parameter int ADDR_W  =
      $clog2(DISPLAY_WIDTH_DEF * DISPLAY_HEIGHT_DEF)
);
   logic               touch_valid;
   logic [8:0]         touch_x;
   logic [8:0]         touch_y;
   logic [R_W-1:0]     brush_r;
   logic [COLOR_W-1:0] paint_color;
   logic               clear_req;
   logic [COLOR_W-1:0] clear_color;
   logic               vram_wr_ena;
   logic [ADDR_W-1:0]  vram_wr_addr;
   logic [COLOR_W-1:0] vram_wr_data;
   logic               busy;
   logic               clear_done;

   modport slave (
      input  touch_valid, touch_x, touch_y, brush_r,
      input  paint_color, clear_req, clear_color,
      output vram_wr_ena, vram_wr_addr, vram_wr_data,
      output busy, clear_done
   );

   modport master (
      output touch_valid, touch_x, touch_y, brush_r,
      output paint_color, clear_req, clear_color,
      input  vram_wr_ena, vram_wr_addr, vram_wr_data,
      input  busy, clear_done
   );
endinterface

// File: rtl/vram_raster_scanner.sv
// Loadable nested x/y raster counter, x inner, y outer, ascending.
// Reset position is (0,0) with full-screen bounds for the boot clear.
module vram_raster_scanner
   import vram_painter_pkg::*;
#(
   parameter int CW     = 9,
   parameter int RST_X1 = DISPLAY_WIDTH_DEF - 1,
   parameter int RST_Y1 = DISPLAY_HEIGHT_DEF - 1
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          start,
   input  logic          step,
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] y1,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          last
);
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic [CW-1:0] xl_q, xl_d, xh_q, xh_d, yh_q, yh_d;

   // load a new box on start, otherwise advance one pixel per step
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      xl_d = xl_q;
      xh_d = xh_q;
      yh_d = yh_q;
      if (start) begin
         x_d  = x0;
         y_d  = y0;
         xl_d = x0;
         xh_d = x1;
         yh_d = y1;
      end else if (step) begin
         if (x_q == xh_q) begin
            x_d = xl_q;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // position and bound registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         x_q  <= '0;
         y_q  <= '0;
         xl_q <= '0;
         xh_q <= CW'(RST_X1);
         yh_q <= CW'(RST_Y1);
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         xl_q <= xl_d;
         xh_q <= xh_d;
         yh_q <= yh_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == xh_q) && (y_q == yh_q);
endmodule

// File: rtl/vram_brush_painter.sv
// Touch-to-VRAM square brush painter with full-screen clear.
// Optional VRAM_BRUSH_PAINTER_DEDUP_EN skips repeats of the last brush.
module vram_brush_painter
   import vram_painter_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
   parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
   parameter int COLOR_W        = $bits(ILI9341_color_t),
   parameter int BRUSH_R_MAX    = 3
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 ena,
   vram_brush_painter_if.slave  bus
);
   localparam int ADDR_W = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT);
   localparam int R_W    = (BRUSH_R_MAX < 1) ? 1 :
                           $clog2(BRUSH_R_MAX + 1);
   localparam int CW     = 9;
   localparam int SW     = CW + 2;

   state_t             state_q, state_d;
   logic [COLOR_W-1:0] clr_col_q, clr_col_d;
   logic [COLOR_W-1:0] pnt_col_q, pnt_col_d;
   logic               pend_q, pend_d;
   logic               fin_q, fin_d;
   logic               done_q;
   logic               busy_q;
   logic               wr_ena_q, wr_ena_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [COLOR_W-1:0] wr_data_q, wr_data_d;

   logic               sc_start, sc_step, sc_last;
   logic [CW-1:0]      sc_x0, sc_x1, sc_y0, sc_y1;
   logic [CW-1:0]      sc_x, sc_y;
   logic [ADDR_W-1:0]  pix_addr;

   logic [R_W-1:0]       r_sat;
   logic signed [SW-1:0] tx_s, ty_s, r_s;
   logic signed [SW-1:0] bx0, bx1, by0, by1;
   logic                 in_range, dup;
   logic                 go_clear, go_brush;

   vram_raster_scanner #(
      .CW     (CW),
      .RST_X1 (DISPLAY_WIDTH - 1),
      .RST_Y1 (DISPLAY_HEIGHT - 1)
   ) u_scan (
      .clk   (clk),
      .rstb  (rstb),
      .start (sc_start),
      .step  (sc_step),
      .x0    (sc_x0),
      .x1    (sc_x1),
      .y0    (sc_y0),
      .y1    (sc_y1),
      .x     (sc_x),
      .y     (sc_y),
      .last  (sc_last)
   );

   assign pix_addr = ADDR_W'(sc_y) * ADDR_W'(DISPLAY_WIDTH)
                   + ADDR_W'(sc_x);

   assign r_sat = (bus.brush_r > R_W'(BRUSH_R_MAX)) ?
                  R_W'(BRUSH_R_MAX) : bus.brush_r;
   assign tx_s  = $signed({2'b00, bus.touch_x});
   assign ty_s  = $signed({2'b00, bus.touch_y});
   assign r_s   = $signed({{(SW-R_W){1'b0}}, r_sat});

   assign in_range = (int'(bus.touch_x) < DISPLAY_WIDTH) &&
                     (int'(bus.touch_y) < DISPLAY_HEIGHT);

   // clip the brush box to the screen in wide signed arithmetic
   always_comb begin
      bx0 = tx_s - r_s;
      bx1 = tx_s + r_s;
      by0 = ty_s - r_s;
      by1 = ty_s + r_s;
      if (bx0 < 0) bx0 = '0;
      if (by0 < 0) by0 = '0;
      if (bx1 > SW'(DISPLAY_WIDTH - 1))
         bx1 = SW'(DISPLAY_WIDTH - 1);
      if (by1 > SW'(DISPLAY_HEIGHT - 1))
         by1 = SW'(DISPLAY_HEIGHT - 1);
   end

   assign go_clear = (state_q == S_IDLE) && ena &&
                     (pend_q || bus.clear_req);
   assign go_brush = (state_q == S_IDLE) && ena && !go_clear &&
                     bus.touch_valid && in_range && !dup;

`ifdef VRAM_BRUSH_PAINTER_DEDUP_EN
   logic               last_vld_q;
   logic [CW-1:0]      last_x_q, last_y_q;
   logic [R_W-1:0]     last_r_q;
   logic [COLOR_W-1:0] last_c_q;

   assign dup = last_vld_q &&
                (last_x_q == bus.touch_x) &&
                (last_y_q == bus.touch_y) &&
                (last_r_q == r_sat) &&
                (last_c_q == bus.paint_color);

   // remember the last painted brush; any clear forgets it
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         last_vld_q <= 1'b0;
         last_x_q   <= '0;
         last_y_q   <= '0;
         last_r_q   <= '0;
         last_c_q   <= '0;
      end else if (go_clear) begin
         last_vld_q <= 1'b0;
      end else if (go_brush) begin
         last_vld_q <= 1'b1;
         last_x_q   <= bus.touch_x;
         last_y_q   <= bus.touch_y;
         last_r_q   <= r_sat;
         last_c_q   <= bus.paint_color;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // next state, scanner control and registered write port
   always_comb begin
      state_d   = state_q;
      clr_col_d = clr_col_q;
      pnt_col_d = pnt_col_q;
      pend_d    = pend_q;
      fin_d     = 1'b0;
      wr_ena_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      sc_start  = 1'b0;
      sc_step   = 1'b0;
      sc_x0     = '0;
      sc_x1     = CW'(DISPLAY_WIDTH - 1);
      sc_y0     = '0;
      sc_y1     = CW'(DISPLAY_HEIGHT - 1);
      unique case (state_q)
         S_CLEAR: begin
            if (ena) begin
               wr_ena_d  = 1'b1;
               wr_addr_d = pix_addr;
               wr_data_d = clr_col_q;
               sc_step   = 1'b1;
               if (sc_last) begin
                  state_d = S_IDLE;
                  fin_d   = 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (bus.clear_req) pend_d = 1'b1;
            if (go_clear) begin
               state_d   = S_CLEAR;
               pend_d    = 1'b0;
               clr_col_d = bus.clear_color;
               sc_start  = 1'b1;
            end else if (go_brush) begin
               state_d   = S_BRUSH;
               pnt_col_d = bus.paint_color;
               sc_start  = 1'b1;
               sc_x0     = bx0[CW-1:0];
               sc_x1     = bx1[CW-1:0];
               sc_y0     = by0[CW-1:0];
               sc_y1     = by1[CW-1:0];
            end
         end
         S_BRUSH: begin
            if (bus.clear_req) pend_d = 1'b1;
            if (ena) begin
               wr_ena_d  = 1'b1;
               wr_addr_d = pix_addr;
               wr_data_d = pnt_col_q;
               sc_step   = 1'b1;
               if (sc_last) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and output registers; reset starts a black clear
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= S_CLEAR;
         clr_col_q <= COLOR_W'(BLACK);
         pnt_col_q <= '0;
         pend_q    <= 1'b0;
         fin_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         wr_ena_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_col_q <= clr_col_d;
         pnt_col_q <= pnt_col_d;
         pend_q    <= pend_d;
         fin_q     <= fin_d;
         done_q    <= fin_q;
         busy_q    <= (state_d != S_IDLE);
         wr_ena_q  <= wr_ena_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.vram_wr_ena  = wr_ena_q;
   assign bus.vram_wr_addr = wr_addr_q;
   assign bus.vram_wr_data = wr_data_q;
   assign bus.busy         = busy_q;
   assign bus.clear_done   = done_q;
endmodule

// File: tb/tb_vram_brush_painter.sv
// Self-checking bench for vram_brush_painter (240x320, r<=3).
// Honours VRAM_BRUSH_PAINTER_DEDUP_EN in its reference model.
module tb_vram_brush_painter;
   localparam int W = 240;
   localparam int H = 320;
   localparam int NPIX = W * H;

   typedef struct {
      int          addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      int          x;
      int          y;
      int          r;
      logic [15:0] c;
      int          n;
      int          first;
      int          last;
   } vec_t;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic ena = 1'b1;

   vram_brush_painter_if #(.COLOR_W(16), .R_W(2), .ADDR_W(17)) bus ();

   vram_brush_painter dut (
      .clk  (clk),
      .rstb (rstb),
      .ena  (ena),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_wr_cyc = -1;
   int done_cyc = -1;
   int done_cnt = 0;
   wr_t wq[$];
   int exp_q[$];

   int          m_vld = 0;
   int          m_x, m_y, m_r;
   logic [15:0] m_c;

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (bus.vram_wr_ena) begin
         wq.push_back('{addr: int'(bus.vram_wr_addr),
                        data: bus.vram_wr_data});
         last_wr_cyc = cyc;
      end
      if (bus.clear_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Reference: expected address list of a touch, in raster order.
   task automatic model_brush(input int x, input int y, input int r,
                              input logic [15:0] c);
      int xa, xb, ya, yb;
      exp_q.delete();
      if (x >= W || y >= H) return;
`ifdef VRAM_BRUSH_PAINTER_DEDUP_EN
      if (m_vld != 0 && m_x == x && m_y == y && m_r == r && m_c == c)
         return;
`endif
      m_vld = 1; m_x = x; m_y = y; m_r = r; m_c = c;
      xa = (x - r < 0) ? 0 : x - r;
      xb = (x + r > W - 1) ? W - 1 : x + r;
      ya = (y - r < 0) ? 0 : y - r;
      yb = (y + r > H - 1) ? H - 1 : y + r;
      for (int yy = ya; yy <= yb; yy++)
         for (int xx = xa; xx <= xb; xx++)
            exp_q.push_back(yy * W + xx);
   endtask

   task automatic check_brush(input string nm, input logic [15:0] c);
      int bad;
      bad = 0;
      chk({nm, " count"}, wq.size(), exp_q.size());
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
         if (wq[i].addr != exp_q[i] || wq[i].data != c) bad++;
      chk({nm, " addr/data errors"}, bad, 0);
   endtask

   task automatic apply_touch(input int x, input int y, input int r,
                              input logic [15:0] c);
      int n;
      wq.delete();
      bus.touch_x = 9'(x);
      bus.touch_y = 9'(y);
      bus.brush_r = 2'(r);
      bus.paint_color = c;
      bus.touch_valid = 1'b1;
      tick();
      bus.touch_valid = 1'b0;
      n = 0;
      while (bus.busy && n < 300) begin
         tick();
         n++;
      end
      chk("brush finishes (busy)", int'(bus.busy), 0);
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, " wr_ena"}, int'(bus.vram_wr_ena), 0);
      chk({nm, " wr_addr"}, int'(bus.vram_wr_addr), 0);
      chk({nm, " wr_data"}, int'(bus.vram_wr_data), 0);
      chk({nm, " busy"}, int'(bus.busy), 0);
      chk({nm, " clear_done"}, int'(bus.clear_done), 0);
   endtask

   vec_t tv[7];

   initial begin
      int n, bad, x, y, r;
      logic [15:0] c;

      tv[0] = '{x: 100, y: 50,  r: 0, c: 16'h07E0,
                n: 1,  first: 12100, last: 12100};
      tv[1] = '{x: 0,   y: 0,   r: 1, c: 16'h001F,
                n: 4,  first: 0,     last: 241};
      tv[2] = '{x: 239, y: 319, r: 2, c: 16'hF81F,
                n: 9,  first: 76317, last: 76799};
      tv[3] = '{x: 240, y: 10,  r: 1, c: 16'h1234,
                n: 0,  first: 0,     last: 0};
      tv[4] = '{x: 5,   y: 320, r: 0, c: 16'h4321,
                n: 0,  first: 0,     last: 0};
      tv[5] = '{x: 3,   y: 200, r: 3, c: 16'hAAAA,
                n: 49, first: 47280, last: 48726};
      tv[6] = '{x: 120, y: 160, r: 3, c: 16'hFFFF,
                n: 49, first: 37797, last: 39243};

      bus.touch_valid = 1'b0;
      bus.touch_x = '0;
      bus.touch_y = '0;
      bus.brush_r = '0;
      bus.paint_color = '0;
      bus.clear_req = 1'b0;
      bus.clear_color = 16'h0000;

      // reset state
      repeat (3) tick();
      chk_zero_outputs("reset");
      rstb = 1'b1;

      // boot clear: every pixel once, ascending, black
      n = 0;
      while (done_cnt == 0 && n < NPIX + 100) begin
         tick();
         n++;
      end
      chk("boot clear write count", wq.size(), NPIX);
      bad = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i].addr != i || wq[i].data != 16'h0000) bad++;
      chk("boot clear sequence errors", bad, 0);
      chk("clear_done one cycle after last write",
          done_cyc - last_wr_cyc, 1);
      chk("busy after clear", int'(bus.busy), 0);
      tick();
      chk("clear_done pulse width", int'(bus.clear_done), 0);
      chk("clear_done pulse count", done_cnt, 1);

      // table of directed touches
      for (int i = 0; i < 7; i++) begin
         model_brush(tv[i].x, tv[i].y, tv[i].r, tv[i].c);
         apply_touch(tv[i].x, tv[i].y, tv[i].r, tv[i].c);
         chk($sformatf("vec%0d count", i), wq.size(), tv[i].n);
         if (tv[i].n > 0 && wq.size() > 0) begin
            chk($sformatf("vec%0d first addr", i),
                wq[0].addr, tv[i].first);
            chk($sformatf("vec%0d last addr", i),
                wq[wq.size()-1].addr, tv[i].last);
         end
         check_brush($sformatf("vec%0d model", i), tv[i].c);
      end

      // random touches against the reference model
      for (int k = 0; k < 40; k++) begin
         x = $urandom_range(0, W + 19);
         y = $urandom_range(0, H + 19);
         r = $urandom_range(0, 3);
         c = 16'($urandom);
         model_brush(x, y, r, c);
         apply_touch(x, y, r, c);
         check_brush($sformatf("rand%0d (%0d,%0d,r%0d)", k, x, y, r),
                     c);
      end

      // ena toggled during a brush: writes only when enabled
      model_brush(50, 60, 2, 16'h0F0F);
      wq.delete();
      bus.touch_x = 9'd50;
      bus.touch_y = 9'd60;
      bus.brush_r = 2'd2;
      bus.paint_color = 16'h0F0F;
      bus.touch_valid = 1'b1;
      tick();
      bus.touch_valid = 1'b0;
      n = 0;
      bad = 0;
      while (bus.busy && n < 400) begin
         ena = 1'($urandom_range(0, 1));
         tick();
         if (bus.vram_wr_ena && !ena) bad++;
         n++;
      end
      ena = 1'b1;
      chk("ena pause finishes", int'(bus.busy), 0);
      chk("writes while ena low", bad, 0);
      check_brush("ena toggle", 16'h0F0F);

      // identical touch repeated
      model_brush(50, 60, 2, 16'h0F0F);
      apply_touch(50, 60, 2, 16'h0F0F);
      check_brush("repeat touch", 16'h0F0F);

      // clear request during a brush: brush completes, then clear
      model_brush(120, 160, 3, 16'hFFE0);
      m_vld = 0;
      wq.delete();
      bus.touch_x = 9'd120;
      bus.touch_y = 9'd160;
      bus.brush_r = 2'd3;
      bus.paint_color = 16'hFFE0;
      bus.touch_valid = 1'b1;
      tick();
      bus.touch_valid = 1'b0;
      repeat (5) tick();
      bus.clear_color = 16'hF800;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      n = 0;
      while (wq.size() < 49 + 300 && n < 1000) begin
         tick();
         n++;
      end
      chk("brush+clear writes collected", wq.size(), 349);
      bad = 0;
      for (int i = 0; i < 49 && i < wq.size(); i++)
         if (wq[i].addr != exp_q[i] || wq[i].data != 16'hFFE0) bad++;
      chk("brush before clear errors", bad, 0);
      bad = 0;
      for (int i = 49; i < wq.size(); i++)
         if (wq[i].addr != i - 49 || wq[i].data != 16'hF800) bad++;
      chk("red clear start errors", bad, 0);
      chk("busy during clear", int'(bus.busy), 1);

      // reset mid-clear: outputs drop at once, clear restarts black
      rstb = 1'b0;
      #1;
      chk_zero_outputs("async reset");
      tick();
      tick();
      rstb = 1'b1;
      wq.delete();
      repeat (200) tick();
      chk("restart clear count", wq.size(), 200);
      bad = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i].addr != i || wq[i].data != 16'h0000) bad++;
      chk("restart clear sequence errors", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
